// File: rtl/bp_outcome_tracker_pkg.sv
// Shared types and helpers for the branch-outcome tracker.
// Optional statistics are enabled by the BP_TRACKER_STATS_EN macro.
package bp_outcome_tracker_pkg;

  typedef struct packed {
    int unsigned VLEN;
    int unsigned INSTR_PER_FETCH;
    logic        RVC;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32'd32, INSTR_PER_FETCH: 32'd2, RVC: 1'b1};

  localparam int unsigned STAT_W = 32;

  function automatic int unsigned slot_width(input int unsigned ipf);
    return (ipf > 32'd1) ? $clog2(ipf) : 32'd1;
  endfunction

  // Saturating increment so long-running statistics never wrap to zero.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) begin
      return v + 32'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/bp_outcome_tracker_if.sv
// Push / resolve / chooser-update bundle between frontend, execute and the tracker.
interface bp_outcome_tracker_if
  import bp_outcome_tracker_pkg::*;
#(
  parameter int unsigned VLEN = 32,
  parameter int unsigned IPF  = 2
);
  localparam int unsigned SLOT_W = slot_width(IPF);

  logic              push_valid;
  logic              push_ready;
  logic [VLEN-1:0]   push_pc;
  logic [SLOT_W-1:0] push_slot;
  logic              push_local_taken;
  logic              push_global_taken;
  logic              resolve_valid;
  logic [VLEN-1:0]   resolve_pc;
  logic              resolve_taken;
  logic              upd_valid;
  logic [VLEN-1:0]   upd_pc;
  logic              upd_taken;
  logic [IPF-1:0]    local_correct;
  logic [IPF-1:0]    global_correct;

  modport master (
    output push_valid, push_pc, push_slot, push_local_taken, push_global_taken,
    output resolve_valid, resolve_pc, resolve_taken,
    input  push_ready, upd_valid, upd_pc, upd_taken, local_correct, global_correct
  );

  modport slave (
    input  push_valid, push_pc, push_slot, push_local_taken, push_global_taken,
    input  resolve_valid, resolve_pc, resolve_taken,
    output push_ready, upd_valid, upd_pc, upd_taken, local_correct, global_correct
  );
endinterface

// File: rtl/bp_outcome_tracker_fifo.sv
// In-order circular buffer of tracked branches; pointers carry an extra wrap bit.
module bp_track_fifo #(
  parameter type         entry_t = logic,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  entry_t                 push_data_i,
  input  logic                   pop_i,
  output entry_t                 head_o,
  output logic                   head_valid_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic [DEPTH-1:0] valid_q;
  entry_t           mem_q [DEPTH];

  assign full_o       = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                        (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  assign empty_o      = (wr_ptr_q == rd_ptr_q);
  assign count_o      = wr_ptr_q - rd_ptr_q;
  assign head_o       = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign head_valid_o = valid_q[rd_ptr_q[PTR_W-1:0]];

  // Callers gate push with !full and pop with !empty, so both never hit one slot.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q[PTR_W-1:0]]   <= push_data_i;
        valid_q[wr_ptr_q[PTR_W-1:0]] <= 1'b1;
        wr_ptr_q                     <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        valid_q[rd_ptr_q[PTR_W-1:0]] <= 1'b0;
        rd_ptr_q                     <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bp_outcome_tracker.sv
// Pairs resolved conditional branches with their recorded predictions and emits chooser updates.
// Optional saturating statistics counters are enabled by BP_TRACKER_STATS_EN.
module bp_outcome_tracker
  import bp_outcome_tracker_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg     = cva6_cfg_empty,
  parameter int unsigned NR_INFLIGHT = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         debug_mode_i,
  bp_outcome_tracker_if.slave          bus,
  output logic                         mismatch_o,
  output logic [$clog2(NR_INFLIGHT):0] count_o
`ifdef BP_TRACKER_STATS_EN
  ,
  output logic [STAT_W-1:0]            stat_resolved_o,
  output logic [STAT_W-1:0]            stat_local_ok_o,
  output logic [STAT_W-1:0]            stat_global_ok_o,
  output logic [STAT_W-1:0]            stat_both_wrong_o
`endif
);
  localparam int unsigned VLEN   = CVA6Cfg.VLEN;
  localparam int unsigned IPF    = CVA6Cfg.INSTR_PER_FETCH;
  localparam int unsigned SLOT_W = slot_width(IPF);

  typedef struct packed {
    logic [VLEN-1:0]   pc;
    logic [SLOT_W-1:0] slot;
    logic              local_taken;
    logic              global_taken;
  } bp_track_entry_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
    logic [IPF-1:0]  local_correct;
    logic [IPF-1:0]  global_correct;
  } bp_chooser_update_t;

  bp_track_entry_t    push_entry_s, head_s;
  bp_chooser_update_t upd_d, upd_q;
  logic               full_s, empty_s, head_valid_s;
  logic               do_push_s, do_pop_s, hit_s, local_ok_s, global_ok_s;
  logic               mismatch_d, mismatch_q;

  assign push_entry_s.pc           = bus.push_pc;
  assign push_entry_s.slot         = CVA6Cfg.RVC ? bus.push_slot : '0;
  assign push_entry_s.local_taken  = bus.push_local_taken;
  assign push_entry_s.global_taken = bus.push_global_taken;

  assign do_push_s   = bus.push_valid && !full_s && !debug_mode_i && !flush_i;
  assign do_pop_s    = bus.resolve_valid && !empty_s && head_valid_s && !flush_i;
  assign hit_s       = do_pop_s && (bus.resolve_pc == head_s.pc);
  assign local_ok_s  = (head_s.local_taken == bus.resolve_taken);
  assign global_ok_s = (head_s.global_taken == bus.resolve_taken);

  bp_track_fifo #(
    .entry_t (bp_track_entry_t),
    .DEPTH   (NR_INFLIGHT)
  ) i_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .push_i       (do_push_s),
    .push_data_i  (push_entry_s),
    .pop_i        (do_pop_s),
    .head_o       (head_s),
    .head_valid_o (head_valid_s),
    .full_o       (full_s),
    .empty_o      (empty_s),
    .count_o      (count_o)
  );

  // Next chooser beat: correctness bits only at the head entry's fetch slot.
  always_comb begin
    upd_d = '0;
    if (hit_s) begin
      upd_d.valid = 1'b1;
      upd_d.pc    = bus.resolve_pc;
      upd_d.taken = bus.resolve_taken;
      for (int i = 0; i < int'(IPF); i++) begin
        upd_d.local_correct[i]  = (head_s.slot == SLOT_W'(i)) && local_ok_s;
        upd_d.global_correct[i] = (head_s.slot == SLOT_W'(i)) && global_ok_s;
      end
    end else begin
      upd_d = '0;
    end
  end

  // Mismatch is sticky until flush or reset.
  always_comb begin
    mismatch_d = mismatch_q;
    if (flush_i) begin
      mismatch_d = 1'b0;
    end else if (do_pop_s && !hit_s) begin
      mismatch_d = 1'b1;
    end else begin
      mismatch_d = mismatch_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      upd_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      upd_q      <= upd_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign bus.push_ready     = !full_s;
  assign bus.upd_valid      = upd_q.valid;
  assign bus.upd_pc         = upd_q.pc;
  assign bus.upd_taken      = upd_q.taken;
  assign bus.local_correct  = upd_q.local_correct;
  assign bus.global_correct = upd_q.global_correct;
  assign mismatch_o         = mismatch_q;

`ifdef BP_TRACKER_STATS_EN
  logic [STAT_W-1:0] stat_res_q, stat_lok_q, stat_gok_q, stat_bw_q;

  // Statistics survive flushes; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stat_res_q <= '0;
      stat_lok_q <= '0;
      stat_gok_q <= '0;
      stat_bw_q  <= '0;
    end else begin
      stat_res_q <= sat_inc(stat_res_q, hit_s);
      stat_lok_q <= sat_inc(stat_lok_q, hit_s && local_ok_s);
      stat_gok_q <= sat_inc(stat_gok_q, hit_s && global_ok_s);
      stat_bw_q  <= sat_inc(stat_bw_q, hit_s && !local_ok_s && !global_ok_s);
    end
  end

  assign stat_resolved_o   = stat_res_q;
  assign stat_local_ok_o   = stat_lok_q;
  assign stat_global_ok_o  = stat_gok_q;
  assign stat_both_wrong_o = stat_bw_q;
`endif

endmodule
